// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the default datapath width.
package alu_seq_pkg;

  localparam int ALU_SEQ_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift-add multiply and, with ALU_SEQ_DIV_EN defined, restoring divide.
// One bit per cycle for WIDTH cycles; done flags the cycle whose closing edge completes the op.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_r, lo_r, opnd;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   sum;

  // Multiply: hi_r accumulates, lo_r starts as the multiplier and shifts right.
  assign sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic             div_mode;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // Divide: hi_r is the partial remainder, lo_r shifts the dividend out and the quotient in.
  assign shifted = {hi_r, lo_r[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd};

  always_comb begin
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo_r[WIDTH-1:1]};
    if (div_mode) begin
      hi_nxt = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      lo_nxt = {lo_r[WIDTH-2:0], ge};
    end
  end
`else
  always_comb begin
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo_r[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      hi_r <= '0;
      lo_r <= '0;
      opnd <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start) begin
      cnt  <= CW'(WIDTH);
      hi_r <= '0;
      lo_r <= a;
      opnd <= b;
`ifdef ALU_SEQ_DIV_EN
      div_mode <= is_div;
`endif
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      hi_r <= hi_nxt;
      lo_r <= lo_nxt;
    end
  end

  assign done = (cnt == CW'(1));
  assign lo   = lo_r;
  assign hi   = hi_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: single-cycle ops plus multi-cycle MULU/DIVU behind a valid/ready handshake.
// DIVU exists only when ALU_SEQ_DIV_EN is defined; otherwise it behaves as an illegal opcode.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  state_t           state, state_nxt;
  logic             accept, is_iter, start, iter_done, sel_iter;
  logic [WIDTH-1:0] alu_res, res_q, iter_lo, iter_hi;

  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
`ifdef ALU_SEQ_DIV_EN
  assign is_iter  = (op == OP_MULU) || (op == OP_DIVU);
`else
  assign is_iter  = (op == OP_MULU);
`endif
  assign start    = accept && is_iter;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_iter ? S_BUSY : S_DONE;
      S_BUSY: if (iter_done) state_nxt = S_DONE;
      S_DONE: begin
        if (accept)         state_nxt = is_iter ? S_BUSY : S_DONE;
        else if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      res_q    <= '0;
      sel_iter <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_q    <= alu_res;
        sel_iter <= is_iter;
      end
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
`ifdef ALU_SEQ_DIV_EN
    .is_div (op == OP_DIVU),
`endif
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  // Iterative results live in the sub-module registers, which stay frozen until the next start.
  assign result    = sel_iter ? iter_lo : res_q;
  assign hi        = sel_iter ? iter_hi : '0;
  assign zero      = (result == '0);
  assign out_valid = (state == S_DONE);

endmodule
